// File: rtl/synced_input_debouncer.sv
// synced_input_debouncer
// Debounces an already-synchronized single-bit input. A new level must be
// seen on DEBOUNCE_CYCLES consecutive enabled edges before it is accepted.
// The block also produces one-cycle rise/fall strobes and a saturating
// count of accepted rising edges. All outputs are registered.
module synced_input_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned EVENT_CNT_WIDTH = 8,
   parameter bit          RESET_LEVEL     = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       in,
   input  logic                       clear_count,
   output logic                       out,
   output logic                       rise,
   output logic                       fall,
   output logic [EVENT_CNT_WIDTH-1:0] event_count
);

   // Stability counter width is derived from the debounce length.
   localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [EVENT_CNT_WIDTH-1:0] EVT_MAX = '1;
   localparam logic [EVENT_CNT_WIDTH-1:0] EVT_ONE = EVENT_CNT_WIDTH'(1);
   // With a one-cycle debounce the first differing sample commits directly,
   // so the pending states are never entered.
   localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      PEND_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      PEND_LOW    = 2'd3
   } state_t;

   localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

   state_t                     state_r, state_nxt;
   logic [CNT_WIDTH-1:0]       cnt_r, cnt_nxt;
   logic                       out_nxt;
   logic                       rise_nxt;
   logic                       fall_nxt;
   logic [EVENT_CNT_WIDTH-1:0] evt_nxt;

   // Next-state, stability counter and strobe decode; everything holds and
   // strobes stay low while enable is deasserted.
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      out_nxt   = out;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      if (enable) begin
         case (state_r)
            STABLE_LOW: begin
               if (in) begin
                  if (SINGLE_CYCLE) begin
                     state_nxt = STABLE_HIGH;
                     out_nxt   = 1'b1;
                     rise_nxt  = 1'b1;
                     cnt_nxt   = '0;
                  end else begin
                     state_nxt = PEND_HIGH;
                     cnt_nxt   = CNT_ONE;
                  end
               end
            end
            PEND_HIGH: begin
               if (!in) begin
                  // Bounce back to the accepted level: restart qualification.
                  state_nxt = STABLE_LOW;
                  cnt_nxt   = '0;
               end else if (cnt_r == CNT_LAST) begin
                  state_nxt = STABLE_HIGH;
                  out_nxt   = 1'b1;
                  rise_nxt  = 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_r + CNT_ONE;
               end
            end
            STABLE_HIGH: begin
               if (!in) begin
                  if (SINGLE_CYCLE) begin
                     state_nxt = STABLE_LOW;
                     out_nxt   = 1'b0;
                     fall_nxt  = 1'b1;
                     cnt_nxt   = '0;
                  end else begin
                     state_nxt = PEND_LOW;
                     cnt_nxt   = CNT_ONE;
                  end
               end
            end
            PEND_LOW: begin
               if (in) begin
                  state_nxt = STABLE_HIGH;
                  cnt_nxt   = '0;
               end else if (cnt_r == CNT_LAST) begin
                  state_nxt = STABLE_LOW;
                  out_nxt   = 1'b0;
                  fall_nxt  = 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_nxt = RESET_STATE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Event counter: clear wins over a coincident rise, otherwise saturate.
   always_comb begin
      evt_nxt = event_count;
      if (clear_count) begin
         evt_nxt = '0;
      end else if (rise_nxt && (event_count != EVT_MAX)) begin
         evt_nxt = event_count + EVT_ONE;
      end
   end

   // State and output registers with asynchronous reset to the reset level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= RESET_STATE;
         cnt_r       <= '0;
         out         <= RESET_LEVEL;
         rise        <= 1'b0;
         fall        <= 1'b0;
         event_count <= '0;
      end else begin
         state_r     <= state_nxt;
         cnt_r       <= cnt_nxt;
         out         <= out_nxt;
         rise        <= rise_nxt;
         fall        <= fall_nxt;
         event_count <= evt_nxt;
      end
   end

endmodule

// File: tb/tb_synced_input_debouncer.sv
// Directed bench for synced_input_debouncer. Three instances share the
// stimulus: a 4-cycle low-reset block with a 2-bit event counter, a 4-cycle
// high-reset block, and a 1-cycle block.
module tb_synced_input_debouncer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic       in = 1'b0;
   logic       clear_count = 1'b0;

   logic       out_l, rise_l, fall_l;
   logic [1:0] evt_l;
   logic       out_h, rise_h, fall_h;
   logic [1:0] evt_h;
   logic       out_o, rise_o, fall_o;
   logic [7:0] evt_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   synced_input_debouncer #(.DEBOUNCE_CYCLES(4), .EVENT_CNT_WIDTH(2), .RESET_LEVEL(1'b0)) dut_l (
      .clk(clk), .rst(rst), .enable(enable), .in(in), .clear_count(clear_count),
      .out(out_l), .rise(rise_l), .fall(fall_l), .event_count(evt_l));

   synced_input_debouncer #(.DEBOUNCE_CYCLES(4), .EVENT_CNT_WIDTH(2), .RESET_LEVEL(1'b1)) dut_h (
      .clk(clk), .rst(rst), .enable(enable), .in(in), .clear_count(clear_count),
      .out(out_h), .rise(rise_h), .fall(fall_h), .event_count(evt_h));

   synced_input_debouncer #(.DEBOUNCE_CYCLES(1), .EVENT_CNT_WIDTH(8), .RESET_LEVEL(1'b0)) dut_o (
      .clk(clk), .rst(rst), .enable(enable), .in(in), .clear_count(clear_count),
      .out(out_o), .rise(rise_o), .fall(fall_o), .event_count(evt_o));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply inputs, take one rising edge, then settle 1 time unit past it.
   task automatic tick(input logic i, input logic en, input logic clr);
      in = i;
      enable = en;
      clear_count = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in = 1'b0;
      enable = 1'b0;
      clear_count = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One clean 4-cycle pulse on the low-reset instance; returns after the
   // rising commit edge (clr applied on that edge) and the falling commit.
   task automatic pulse_l(input logic clr_on_rise, input int idx, input logic [1:0] exp_evt);
      for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, clr_on_rise);
      check($sformatf("sat_rise%0d", idx), rise_l, 1'b1);
      check($sformatf("sat_evt%0d", idx), evt_l, exp_evt);
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 1'b0);
      check($sformatf("sat_fall%0d", idx), fall_l, 1'b1);
   endtask

   initial begin
      logic [7:0] in_v, rise_v, fall_v, en_v;

      // Reset values and basic 4-cycle latency
      do_reset();
      check("rst_out_l", out_l, 1'b0);
      check("rst_rise_l", rise_l, 1'b0);
      check("rst_fall_l", fall_l, 1'b0);
      check("rst_evt_l", evt_l, 2'd0);
      check("rst_out_h", out_h, 1'b1);
      check("rst_out_o", out_o, 1'b0);
      for (int e = 0; e < 3; e++) begin
         tick(1'b1, 1'b1, 1'b0);
         check($sformatf("lat_out_e%0d", e), out_l, 1'b0);
         check($sformatf("lat_rise_e%0d", e), rise_l, 1'b0);
      end
      tick(1'b1, 1'b1, 1'b0);
      check("lat_out_e3", out_l, 1'b1);
      check("lat_rise_e3", rise_l, 1'b1);
      check("lat_evt_e3", evt_l, 2'd1);
      tick(1'b1, 1'b1, 1'b0);
      check("lat_rise_e4", rise_l, 1'b0);
      check("lat_out_e4", out_l, 1'b1);
      check("lat_evt_e4", evt_l, 2'd1);

      // Bounce: 1,1,1,0 then 1,1,1,1; only the last edge commits
      do_reset();
      in_v   = 8'b1111_0111;   // bit k is edge k
      rise_v = 8'b1000_0000;
      for (int k = 0; k < 8; k++) begin
         tick(in_v[k], 1'b1, 1'b0);
         check($sformatf("bnc_rise%0d", k), rise_l, rise_v[k]);
         check($sformatf("bnc_out%0d", k), out_l, rise_v[k]);
         check($sformatf("bnc_fall%0d", k), fall_l, 1'b0);
      end

      // Enable gating: 1,1,0,0,1,1 commits on the 6th edge
      do_reset();
      en_v   = 8'b0011_0011;
      rise_v = 8'b0010_0000;
      for (int k = 0; k < 6; k++) begin
         tick(1'b1, en_v[k], 1'b0);
         check($sformatf("en_rise%0d", k), rise_l, rise_v[k]);
         check($sformatf("en_out%0d", k), out_l, rise_v[k]);
      end

      // Saturation of the 2-bit counter and clear priority
      do_reset();
      pulse_l(1'b0, 1, 2'd1);
      pulse_l(1'b0, 2, 2'd2);
      pulse_l(1'b0, 3, 2'd3);
      pulse_l(1'b0, 4, 2'd3);
      pulse_l(1'b0, 5, 2'd3);
      pulse_l(1'b1, 6, 2'd0);
      pulse_l(1'b0, 7, 2'd1);
      tick(1'b0, 1'b0, 1'b1);
      check("clr_disabled", evt_l, 2'd0);

      // Single-cycle debounce: out follows in one edge later
      do_reset();
      in_v   = 8'b0011_0011;
      rise_v = 8'b0001_0001;
      fall_v = 8'b0100_0100;
      for (int k = 0; k < 8; k++) begin
         tick(in_v[k], 1'b1, 1'b0);
         check($sformatf("one_out%0d", k), out_o, in_v[k]);
         check($sformatf("one_rise%0d", k), rise_o, rise_v[k]);
         check($sformatf("one_fall%0d", k), fall_o, fall_v[k]);
      end
      check("one_evt", evt_o, 8'd2);

      // High reset level: build an event, then reset asynchronously mid PEND_LOW
      do_reset();
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 1'b0);
      check("hi_fall", fall_h, 1'b1);
      for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b0);
      check("hi_rise", rise_h, 1'b1);
      check("hi_evt", evt_h, 2'd1);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      check("hi_pend_out", out_h, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("hi_async_evt", evt_h, 2'd0);
      check("hi_async_out", out_h, 1'b1);
      check("hi_async_fall", fall_h, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b1, 1'b0);
         check($sformatf("hi_restart_out%0d", k), out_h, 1'b1);
         check($sformatf("hi_restart_fall%0d", k), fall_h, 1'b0);
      end
      tick(1'b0, 1'b1, 1'b0);
      check("hi_restart_commit", fall_h, 1'b1);
      check("hi_restart_outlow", out_h, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
